// File: rtl/multicycle_sequencer_pkg.sv
// Shared types for the RV32I multi-cycle sequencer: FSM state encoding and small helpers.
package multicycle_sequencer_pkg;

  // Encodings are visible on state_o, so they are pinned explicitly.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StMem     = 3'd4,
    StWb      = 3'd5,
    StHalt    = 3'd6,
    StError   = 3'd7
  } seq_state_e;

  function automatic logic is_wait_state(input seq_state_e st);
    return (st == StFetch) || (st == StMem);
  endfunction

  function automatic logic is_counting_state(input seq_state_e st);
    return !((st == StIdle) || (st == StHalt) || (st == StError));
  endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Counts cycles a memory request has waited without ack; expired once MEM_TIMEOUT is reached.
module multicycle_sequencer_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(MEM_TIMEOUT);

  logic [CntW-1:0] count_q, count_d;

  // Saturates at the limit so a held request can never wrap back below it.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != Limit)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == Limit);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory handshakes,
// halt on SYSTEM, timeout error, and cycle/instret counters.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_i,
  input  logic                 regwren_i,
  input  logic                 memren_i,
  input  logic                 memwren_i,
  input  logic                 pcsel_i,
  input  logic                 br_taken_i,
  input  logic                 is_system_i,
  input  logic                 imem_ack_i,
  input  logic                 dmem_ack_i,
  output logic                 imem_req_o,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic                 ir_we_o,
  output logic                 rf_we_o,
  output logic                 pc_we_o,
  output logic                 pc_redirect_o,
  output logic                 retire_o,
  output logic                 halt_o,
  output logic                 err_o,
  output logic [2:0]           state_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instret_o
);

  seq_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 wait_ack;
  logic                 timer_clear;
  logic                 timer_tick;
  logic                 timer_expired;

  // One timer serves both FETCH and MEM; it restarts whenever neither is active.
  assign wait_ack    = ((state_q == StFetch) && imem_ack_i) || ((state_q == StMem) && dmem_ack_i);
  assign timer_clear = !is_wait_state(state_q);
  assign timer_tick  = !timer_clear && !wait_ack;

  multicycle_sequencer_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (timer_clear),
    .tick_i   (timer_tick),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    imem_req_o    = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    ir_we_o       = 1'b0;
    rf_we_o       = 1'b0;
    pc_we_o       = 1'b0;
    pc_redirect_o = 1'b0;
    retire_o      = 1'b0;
    halt_o        = 1'b0;
    err_o         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        imem_req_o = 1'b1;
        // An ack on the expiry cycle still completes the fetch.
        if (imem_ack_i) begin
          ir_we_o = 1'b1;
          state_d = StDecode;
        end else if (timer_expired) begin
          state_d = StError;
        end
      end
      StDecode: begin
        state_d = is_system_i ? StHalt : StExecute;
      end
      StExecute: begin
        state_d = (memren_i || memwren_i) ? StMem : StWb;
      end
      StMem: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = memwren_i;
        if (dmem_ack_i) begin
          state_d = StWb;
        end else if (timer_expired) begin
          state_d = StError;
        end
      end
      StWb: begin
        rf_we_o       = regwren_i;
        pc_we_o       = 1'b1;
        pc_redirect_o = pcsel_i && br_taken_i;
        retire_o      = 1'b1;
        state_d       = run_i ? StFetch : StIdle;
      end
      StHalt: begin
        halt_o = 1'b1;
      end
      StError: begin
        err_o = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instret_d   = instret_q;
    if (is_counting_state(state_q)) cycle_cnt_d = cycle_cnt_q + 1'b1;
    if (retire_o) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      instret_q   <= instret_d;
    end
  end

  assign state_o     = state_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;

endmodule
